// File: rtl/wb_cmd_master_pkg.sv
// rtl/wb_cmd_master_pkg.sv - shared state encoding and constants for wb_cmd_master
package wb_cmd_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_RSP_DAT = 32'h0;

  // Counter must hold 0..TIMEOUT; a disabled timeout still needs one bit.
  function automatic int ctr_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_cmd_master_if.sv
// rtl/wb_cmd_master_if.sv - command stream, response and Wishbone master signals
interface wb_cmd_master_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;

  logic        rsp_valid;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, wbm_ack_i, wbm_dat_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, wbm_ack_i, wbm_dat_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

endinterface

// File: rtl/wb_cmd_master_timeout_ctr.sv
// rtl/wb_cmd_master_timeout_ctr.sv - saturating bus-cycle counter with clear/enable/hit
module wb_cmd_master_timeout_ctr
  import wb_cmd_master_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  localparam int CW = ctr_width(TIMEOUT);
  localparam logic [CW-1:0] HIT_VAL = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX_VAL = '1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != MAX_VAL)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_hit = (TIMEOUT != 0) && (r_cnt == HIT_VAL);

endmodule

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - one Wishbone classic read/write per command, ack or timeout response
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_cmd_master_if.master  bus
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;
  logic        w_ack_done;
  logic        w_to_done;
  logic        w_hit;

  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_dat;
  logic        r_cyc;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ack_done  = 1'b0;
    w_to_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid && r_cmd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BUS;
        end
      end
      ST_BUS: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (bus.wbm_ack_i) begin
          w_ack_done  = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_hit) begin
          w_to_done   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  wb_cmd_master_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .i_clk (wb_clk_i),
    .i_rst (wb_rst_i),
    .i_clr (w_accept),
    .i_en  ((r_state == ST_BUS) && !w_ack_done && !w_to_done),
    .o_hit (w_hit)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_dat   <= '0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= w_ack_done || w_to_done;
      if (w_accept) begin
        r_cyc <= 1'b1;
        r_we  <= bus.cmd_we;
        r_sel <= bus.cmd_sel;
        r_adr <= bus.cmd_adr;
        r_dat <= bus.cmd_dat;
      end else if (w_ack_done || w_to_done) begin
        r_cyc <= 1'b0;
      end
      if (w_ack_done) begin
        r_rsp_dat <= r_we ? '0 : bus.wbm_dat_i;
        r_rsp_err <= 1'b0;
      end else if (w_to_done) begin
        r_rsp_dat <= TIMEOUT_RSP_DAT;
        r_rsp_err <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_dat   = r_rsp_dat;
  assign bus.wbm_cyc_o = r_cyc;
  assign bus.wbm_stb_o = r_cyc;
  assign bus.wbm_we_o  = r_we;
  assign bus.wbm_sel_o = r_sel;
  assign bus.wbm_adr_o = r_adr;
  assign bus.wbm_dat_o = r_dat;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - randomized self-checking bench for wb_cmd_master
module tb_wb_cmd_master;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  wb_cmd_master_if bus();

  wb_cmd_master #(.TIMEOUT(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave acks on stb cycle waits+1; anything past the timeout window never acks.
  task automatic model(input bit we, input int waits, input logic [31:0] rdata,
                       output int stb_cycles, output bit err, output logic [31:0] dat);
    err        = (waits >= TO);
    stb_cycles = err ? TO : waits + 1;
    dat        = (err || we) ? 32'h0 : rdata;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!bus.cmd_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(input bit we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, input int waits, input logic [31:0] rdata,
                         input bit stray);
    int          stb_n = 0;
    int          guard = 0;
    int          exp_stb;
    bit          exp_err;
    logic [31:0] exp_dat;
    model(we, waits, rdata, exp_stb, exp_err, exp_dat);
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_sel   = sel;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = ~we;
    bus.cmd_adr   = $urandom;
    bus.cmd_dat   = $urandom;
    while (bus.wbm_stb_o && guard < 20) begin
      stb_n++;
      guard++;
      if (stb_n == 1) begin
        chk("bus_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        chk("bus_we", 32'(bus.wbm_we_o), 32'(we));
        chk("bus_sel", 32'(bus.wbm_sel_o), 32'(sel));
        chk("bus_adr", bus.wbm_adr_o, adr);
        chk("bus_dat", bus.wbm_dat_o, dat);
        chk("bus_ready", 32'(bus.cmd_ready), 32'd0);
        chk("bus_rsp", 32'(bus.rsp_valid), 32'd0);
      end
      bus.wbm_ack_i = (stb_n == waits + 1);
      bus.wbm_dat_i = bus.wbm_ack_i ? rdata : $urandom;
      @(negedge clk);
    end
    bus.wbm_ack_i = stray;
    bus.wbm_dat_i = $urandom;
    chk("stb_cycles", 32'(stb_n), 32'(exp_stb));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    chk("rsp_dat", bus.rsp_dat, exp_dat);
    chk("rsp_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    chk("rsp_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_ready", 32'(bus.cmd_ready), 32'd1);
    chk("post_rsp_dat_hold", bus.rsp_dat, exp_dat);
    chk("post_adr_hold", bus.wbm_adr_o, adr);
    if (stray) begin
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        chk("stray_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("stray_cyc", 32'(bus.wbm_cyc_o), 32'd0);
      end
      chk("stray_err_hold", 32'(bus.rsp_err), 32'(exp_err));
    end
    bus.wbm_ack_i = 1'b0;
  endtask

  task automatic run_b2b();
    logic [31:0] adrs [3];
    int          acc_cyc [3];
    int          n_acc = 0;
    int          n_stb = 0;
    int          n_rsp = 0;
    bit          acc_now;
    for (int i = 0; i < 3; i++) adrs[i] = $urandom;
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_sel   = 4'hF;
    bus.cmd_adr   = adrs[0];
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'h5A5A_0000;
    for (int c = 0; c < 20; c++) begin
      if (bus.wbm_stb_o) begin
        if (n_stb < 3) chk("b2b_adr", bus.wbm_adr_o, adrs[n_stb]);
        n_stb++;
      end
      if (bus.rsp_valid) n_rsp++;
      acc_now = bus.cmd_valid && bus.cmd_ready;
      if (acc_now && n_acc < 3) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      @(negedge clk);
      if (acc_now) begin
        if (n_acc < 3) bus.cmd_adr = adrs[n_acc];
        else bus.cmd_valid = 1'b0;
      end
    end
    bus.cmd_valid = 1'b0;
    bus.wbm_ack_i = 1'b0;
    chk("b2b_accepts", 32'(n_acc), 32'd3);
    chk("b2b_stb", 32'(n_stb), 32'd3);
    chk("b2b_rsp", 32'(n_rsp), 32'd3);
    if (n_acc == 3) begin
      chk("b2b_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      chk("b2b_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    end
  endtask

  task automatic run_reset_in_bus();
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = 32'h3000_0010;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("rst_stb1", 32'(bus.wbm_stb_o), 32'd1);
    @(negedge clk);
    chk("rst_stb2", 32'(bus.wbm_stb_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
    chk("rst_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("rst_ready_low", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk("rst_ready_back", 32'(bus.cmd_ready), 32'd1);
    chk("rst_rsp_after", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("rst_rsp_after2", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_sel   = 4'h0;
    bus.cmd_adr   = 32'h0;
    bus.cmd_dat   = 32'h0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_dat", bus.rsp_dat, 32'h0);
    chk("rst_cyc0", 32'(bus.wbm_cyc_o), 32'd0);
    chk("rst_stb0", 32'(bus.wbm_stb_o), 32'd0);
    chk("rst_we", 32'(bus.wbm_we_o), 32'd0);
    chk("rst_sel", 32'(bus.wbm_sel_o), 32'd0);
    chk("rst_adr", bus.wbm_adr_o, 32'h0);
    chk("rst_dat", bus.wbm_dat_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

    run_cmd(1'b1, 4'hF, 32'h3000_0000, 32'h0000_00A5, 0, 32'hDEAD_BEEF, 1'b0);
    run_cmd(1'b0, 4'hF, 32'h3000_0004, 32'h0, 3, 32'h1234_5678, 1'b0);
    run_cmd(1'b0, 4'h3, 32'h3000_0008, 32'h0, 50, 32'hFFFF_FFFF, 1'b1);
    run_cmd(1'b0, 4'hC, 32'h3000_000C, 32'h0, TO - 1, 32'hCAFE_F00D, 1'b0);
    run_b2b();
    run_reset_in_bus();

    for (int i = 0; i < 40; i++) begin
      run_cmd(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
              $urandom_range(0, 6), $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic single-cycle master that turns a simple valid/ready command stream into one Wishbone read or write cycle at a time. It is the initiator counterpart of the user-project Wishbone slave. It lets logic-analyzer or GPIO-driven test logic inside the user area exercise the slave registers without the management SoC. Every cycle terminates with a response: either the slave's ack or a bus timeout.

## Interface
Parameters:
- TIMEOUT, 255: number of cycles in BUS without ack before the cycle is aborted. 0 disables the timeout.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- wb_clk_i  in  1  clock; all logic on the rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_sel  in  4  byte lane selects.
- cmd_adr  in  32  byte address.
- cmd_dat  in  32  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_dat  out  32  read data; 0 for writes and timeouts.
- rsp_err  out  1  qualified by rsp_valid; 1 = timeout.
- wbm_cyc_o, wbm_stb_o  out  1 each  bus cycle / strobe, always driven identically.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte selects.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  32  slave read data.

## Operation
FSM states:
- IDLE: cmd_ready = 1. When cmd_valid && cmd_ready, register we/sel/adr/dat into the wbm_* output registers, clear the timeout counter, and go to BUS.
- BUS: cyc = stb = 1 and cmd_ready = 0.
  - If wbm_ack_i is sampled 1: capture wbm_dat_i when !we (capture 0 when we), set rsp_err = 0, and go to RESP.
  - Else, if TIMEOUT != 0 and the counter equals TIMEOUT-1: set rsp_dat = 0, set rsp_err = 1, and go to RESP.
  - Otherwise increment the counter.
- RESP: cyc = stb = 0, rsp_valid = 1 for exactly this cycle, cmd_ready = 0. Go to IDLE.

Rules:
- wbm_ack_i is ignored outside BUS; a late ack after a timeout must not produce a second response.
- An ack on the same cycle the counter reaches TIMEOUT-1 wins, giving a normal response with rsp_err = 0.
- Command inputs are ignored while cmd_ready = 0; no queueing is done.
- wbm_we/sel/adr/dat_o hold their values from the BUS cycle until the next accept.
- rsp_dat and rsp_err hold their values until the next RESP; only rsp_valid pulses.
- Timeout counter width is $clog2(TIMEOUT+1), minimum 1 bit. It saturates and never wraps.

## Timing
- Reset values at the edge where wb_rst_i = 1:
  - State = IDLE.
  - cmd_ready = 0 during reset, and 1 on the first cycle after it.
  - rsp_valid = 0, rsp_err = 0, rsp_dat = 0.
  - cyc = stb = we = 0, sel = 0, adr = 0, dat = 0.
- Reset mid-cycle (in BUS or RESP): cyc/stb drop at that edge and no response is issued.
- Accept at edge N: cyc/stb are high from N+1.
- If ack is seen at edge N+1+k (k ≥ 0): rsp_valid is high during cycle N+2+k, and cmd_ready returns during N+3+k.
- Minimum command-to-command spacing is 3 cycles (zero-wait slave).
- Timeout case: stb is high for exactly TIMEOUT cycles, then rsp_valid with rsp_err = 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package: state encoding (IDLE/BUS/RESP) and the timeout-response data constant (32'h0).
- Single module. The optional sub-module wb_timeout_ctr holds the saturating counter with clear/enable/hit.
- Top-level integration: drives the user_proj Wishbone slave inputs through a mux selected by an LA bit. This mux is not part of this block.

## Test plan
1. Zero-wait write: accept cmd (we = 1, adr = 32'h3000_0000, dat = 32'h0000_00A5, sel = 4'hF), slave acks on the first stb cycle -> stb high for exactly 1 cycle, rsp_valid 2 cycles after accept, rsp_err = 0, rsp_dat = 0.
2. Read with wait states: slave acks after 3 wait cycles with dat_i = 32'h1234_5678 -> stb high for 4 cycles, rsp_dat = 32'h1234_5678, rsp_err = 0.
3. Timeout: TIMEOUT = 4, slave never acks -> stb high for exactly 4 cycles, then rsp_valid with rsp_err = 1 and rsp_dat = 0. A stray ack 2 cycles later produces no response.
4. Ack on the final timeout cycle (TIMEOUT = 4, ack on stb cycle 4) -> rsp_err = 0, read data captured.
5. Back-to-back: cmd_valid held high with 3 commands -> each accepted exactly once, spacing 3 cycles with a zero-wait slave, and commands presented during BUS are not accepted.
6. Reset in BUS (assert wb_rst_i for 1 cycle at stb cycle 2) -> cyc/stb = 0 at that edge, no rsp_valid, cmd_ready = 1 the following cycle.
